// File: rtl/clock_rst_pkg.sv
// Shared types for the clock_rst stimulus generator: FSM states, default counter
// width and the configuration record latched on run.
package clock_rst_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN
  } state_e;

  // Fields are CNT_W_DEF wide; instances must keep CNT_W <= CNT_W_DEF.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] rst_cycles;
    logic [CNT_W_DEF-1:0] half_period;
    logic                 init_level;
  } cfg_t;

endpackage

// File: rtl/clock_rst_div.sv
// Half-period divider: counts clk cycles and toggles the generated clock every
// half_period_i cycles; load_i restarts it at init_level_i and beats a toggle.
module clock_rst_div
  import clock_rst_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             init_level_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] half_period_i,
  output logic             clock_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clock_q, clock_d;
  logic             tick;

  assign tick    = en_i && (cnt_q == half_period_i - CNT_W'(1));
  assign rise_o  = tick && !load_i && !clock_q;
  assign fall_o  = tick && !load_i &&  clock_q;
  assign clock_o = clock_q;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    clock_d = clock_q;
    if (load_i) begin
      cnt_d   = '0;
      clock_d = init_level_i;
    end else if (tick) begin
      cnt_d   = '0;
      clock_d = !clock_q;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clock_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clock_q <= clock_d;
    end
  end

endmodule

// File: rtl/clock_rst.sv
// Programmable test clock and polarity-configurable reset generator.
// Optional cycle counter output cyc_cnt_o is enabled by defining CLOCK_RST_CYCLE_CNT_EN.
module clock_rst
  import clock_rst_pkg::*;
#(
  parameter bit ACTIVE = 1'b0,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] rst_cycles_i,
  input  logic [CNT_W-1:0] half_period_i,
  input  logic             init_level_i,
  output logic             clock,
  output logic             rst,
  output logic             busy_o
`ifdef CLOCK_RST_CYCLE_CNT_EN
  ,
  output logic [31:0]      cyc_cnt_o
`endif
);

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic             rst_q, rst_d;
  logic             busy, div_load, div_level, div_rise, div_fall;
  logic [CNT_W-1:0] hp_eff;

  assign busy   = (state_q != ST_IDLE);
  assign hp_eff = (half_period_i == '0) ? CNT_W'(1) : half_period_i;

  // A run pulse in IDLE or a stop pulse while busy restarts the divider at the init level.
  assign div_load  = busy ? stop_i : run_i;
  assign div_level = busy ? cfg_q.init_level : init_level_i;

  clock_rst_div #(.CNT_W(CNT_W)) u_div (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (div_load),
    .init_level_i (div_level),
    .en_i         (busy),
    .half_period_i(CNT_W'(cfg_q.half_period)),
    .clock_o      (clock),
    .rise_o       (div_rise),
    .fall_o       (div_fall)
  );

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    rise_cnt_d = rise_cnt_q;
    rst_d      = rst_q;
    unique case (state_q)
      ST_IDLE: begin
        rst_d = ACTIVE;
        if (run_i) begin
          cfg_d.rst_cycles  = CNT_W_DEF'(rst_cycles_i);
          cfg_d.half_period = CNT_W_DEF'(hp_eff);
          cfg_d.init_level  = init_level_i;
          rise_cnt_d        = '0;
          if (rst_cycles_i != '0) begin
            state_d = ST_RESET;
          end else begin
            state_d = ST_RUN;
            rst_d   = ~ACTIVE;
          end
        end
      end
      ST_RESET: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          rst_d   = ACTIVE;
        end else begin
          if (div_rise) rise_cnt_d = rise_cnt_q + CNT_W'(1);
          // Release on the falling toggle after the last counted rise: half a period after it.
          if (div_fall && rise_cnt_q == CNT_W'(cfg_q.rst_cycles)) begin
            state_d = ST_RUN;
            rst_d   = ~ACTIVE;
          end
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          rst_d   = ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rst_d   = ACTIVE;
      end
    endcase
  end

  // NOTE: the latched config is small flop storage, so it is cleared by rst_n like all other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      rise_cnt_q <= '0;
      rst_q      <= ACTIVE;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      rise_cnt_q <= rise_cnt_d;
      rst_q      <= rst_d;
    end
  end

  assign rst    = rst_q;
  assign busy_o = busy;

`ifdef CLOCK_RST_CYCLE_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (state_d == ST_RUN && state_q != ST_RUN) begin
      cyc_cnt_d = '0;
    end else if (state_q == ST_RUN && div_rise) begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_cnt_q <= '0;
    else        cyc_cnt_q <= cyc_cnt_d;
  end

  assign cyc_cnt_o = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_clock_rst.sv
// Scoreboard bench for clock_rst: an ACTIVE=0 and an ACTIVE=1 instance share stimulus;
// expected outputs come from closed-form timing of the generated clock and reset.
module tb_clock_rst;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_i, stop_i, init_level_i;
  logic [15:0] rst_cycles_i, half_period_i;
  logic        clock0, rst0, busy0;
  logic        clock1, rst1, busy1;
`ifdef CLOCK_RST_CYCLE_CNT_EN
  logic [31:0] cyc0, cyc1;
`endif

  always #5 clk = ~clk;

  clock_rst #(.ACTIVE(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .stop_i(stop_i),
    .rst_cycles_i(rst_cycles_i), .half_period_i(half_period_i), .init_level_i(init_level_i),
    .clock(clock0), .rst(rst0), .busy_o(busy0)
`ifdef CLOCK_RST_CYCLE_CNT_EN
    , .cyc_cnt_o(cyc0)
`endif
  );

  clock_rst #(.ACTIVE(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .stop_i(stop_i),
    .rst_cycles_i(rst_cycles_i), .half_period_i(half_period_i), .init_level_i(init_level_i),
    .clock(clock1), .rst(rst1), .busy_o(busy1)
`ifdef CLOCK_RST_CYCLE_CNT_EN
    , .cyc_cnt_o(cyc1)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  typedef struct {
    logic        clock;
    logic        released;   // reset deasserted
    logic        busy;
    logic        cyc_valid;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: t counts edges since the run edge (t=1 just after it).
  bit          m_busy = 1'b0;
  bit          m_init = 1'b0;
  int unsigned m_t, m_hp, m_nrel, m_trel;

  function automatic int unsigned rises_upto(input int unsigned n, input bit init);
    return init ? n / 2 : (n + 1) / 2;
  endfunction

  task automatic step(input bit run, input bit stop, input int unsigned rc,
                      input int unsigned hp, input bit init);
    exp_t        e;
    int unsigned n_tog;
    run_i         = run;
    stop_i        = stop;
    rst_cycles_i  = rc[15:0];
    half_period_i = hp[15:0];
    init_level_i  = init;
    @(posedge clk);
    if (!m_busy) begin
      if (run) begin
        m_busy = 1'b1;
        m_t    = 1;
        m_init = init;
        m_hp   = (hp == 0) ? 1 : hp;
        // Release toggle: the falling toggle right after the rc-th rising toggle.
        m_nrel = (rc == 0) ? 0 : (init ? 2 * rc + 1 : 2 * rc);
        m_trel = m_nrel * m_hp + 1;
      end
    end else if (stop) begin
      m_busy = 1'b0;
    end else begin
      m_t++;
    end
    if (m_busy) begin
      n_tog       = (m_t - 1) / m_hp;
      e.clock     = m_init ^ n_tog[0];
      e.released  = (m_t >= m_trel);
      e.busy      = 1'b1;
      e.cyc_valid = e.released;
      e.cyc       = rises_upto(n_tog, m_init) - rises_upto(m_nrel, m_init);
    end else begin
      e.clock     = m_init;
      e.released  = 1'b0;
      e.busy      = 1'b0;
      e.cyc_valid = 1'b0;
      e.cyc       = '0;
    end
    sb_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic hold(input int n, input int unsigned rc, input int unsigned hp, input bit init);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rc, hp, init);
  endtask

  task automatic check_reset_state();
    check("rst_clock0", clock0, 0);
    check("rst_rst0",   rst0,   0);
    check("rst_busy0",  busy0,  0);
    check("rst_clock1", clock1, 0);
    check("rst_rst1",   rst1,   1);
    check("rst_busy1",  busy1,  0);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("clock0", clock0, e.clock);
      check("rst0",   rst0,   e.released);
      check("busy0",  busy0,  e.busy);
      check("clock1", clock1, e.clock);
      check("rst1",   rst1,   !e.released);
      check("busy1",  busy1,  e.busy);
`ifdef CLOCK_RST_CYCLE_CNT_EN
      if (e.cyc_valid) begin
        check("cyc0", cyc0, e.cyc);
        check("cyc1", cyc1, e.cyc);
      end
`endif
    end
  end

  initial begin
    rst_n = 1'b1;
    run_i = 1'b0; stop_i = 1'b0; init_level_i = 1'b0;
    rst_cycles_i = '0; half_period_i = '0;
    #1 rst_n = 1'b0;
    #2 check_reset_state();
    @(posedge clk); #1;
    check_reset_state();
    rst_n = 1'b1;
    idle(5);

    // Long reset: 10 rising edges at a 62-cycle period; run and new config mid-run are ignored.
    step(1'b1, 1'b0, 10, 31, 1'b0);
    hold(300, 10, 31, 1'b0);
    step(1'b1, 1'b0, 3, 7, 1'b1);
    hold(400, 2, 5, 1'b1);
    step(1'b1, 1'b0, 1, 1, 1'b1);
    hold(80, 1, 1, 1'b1);
    step(1'b0, 1'b1, 0, 0, 1'b0);
    idle(5);

    // Zero reset length and zero half period: run at once, toggle every cycle, count 100+ rises.
    step(1'b1, 1'b0, 0, 0, 1'b0);
    hold(210, 0, 0, 1'b0);
    step(1'b1, 1'b1, 0, 0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 0, 3, 1'b1);
    hold(30, 0, 3, 1'b1);
    step(1'b0, 1'b1, 0, 0, 1'b0);
    idle(3);

    // Init high, two rising edges of reset; stop once inside RESET, then run it to completion.
    step(1'b1, 1'b0, 2, 4, 1'b1);
    hold(10, 2, 4, 1'b1);
    step(1'b0, 1'b1, 2, 4, 1'b1);
    idle(3);
    step(1'b1, 1'b0, 2, 4, 1'b1);
    hold(60, 2, 4, 1'b1);
    step(1'b0, 1'b1, 0, 0, 1'b0);
    idle(3);

    // Run and stop together in IDLE: run wins.
    step(1'b1, 1'b1, 3, 2, 1'b0);
    hold(40, 3, 2, 1'b0);
    step(1'b0, 1'b1, 0, 0, 1'b0);
    idle(2);

    // Asynchronous reset in the middle of a run clears state and the latched init level.
    step(1'b1, 1'b0, 0, 5, 1'b1);
    hold(12, 0, 5, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    m_busy = 1'b0;
    m_init = 1'b0;
    #1 check_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    @(negedge clk); #1;
    check("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_rst.md
Name: clock_rst

Overview:
- Synthesizable clock/reset stimulus generator.
- Derives a slow, programmable test clock and a polarity-configurable reset from the system clock.
- Drives SPI-style verification models and peripheral blocks that need a clean clock plus a reset held for N generated clock periods.
- Started with a one-cycle run pulse carrying: reset length, half period, initial clock level.

Parameters:
- ACTIVE, 0: logic level of rst when asserted (0 = active-low reset out, 1 = active-high).
- CNT_W, 16: width of the reset-length and half-period configuration fields and their counters.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run_i  input  1  single-cycle start pulse; sampled only in IDLE.
- stop_i  input  1  single-cycle stop pulse; returns block to IDLE.
- rst_cycles_i  input  CNT_W  number of generated-clock rising edges during which rst stays asserted.
- half_period_i  input  CNT_W  clk cycles per half period of the generated clock; 0 treated as 1.
- init_level_i  input  1  level of generated clock on entry to RESET and while IDLE.
- clock  output  1  generated clock, registered.
- rst  output  1  generated reset, registered, asserted level = ACTIVE.
- busy_o  output  1  high in RESET or RUN.

Behaviour:
- Async reset (rst_n=0):
  - state=IDLE, clock=0, rst=ACTIVE, busy_o=0.
  - Latched config cleared to 0; counters cleared.
- States: IDLE, RESET, RUN; encoded as an enum in the package.
- IDLE:
  - clock holds latched init level; rst=ACTIVE; busy_o=0.
  - On run_i=1: latch rst_cycles_i, max(half_period_i,1), init_level_i.
  - Next cycle: clock=init_level_i, half counter=0.
  - Go to RESET if rst_cycles_i!=0, else RUN with rst deasserted (~ACTIVE) on that same edge.
- Half-period counter (RESET and RUN):
  - Increments every clk cycle.
  - When it equals latched half_period-1: clock toggles and counter resets to 0.
  - Each clock level lasts exactly half_period clk cycles; period = 2*half_period.
- RESET:
  - Counts clock 0->1 toggles.
  - On the toggle edge producing the next falling transition after the rst_cycles-th rising toggle: rst goes ~ACTIVE and state goes RUN.
  - Reset release is always half a period away from the rising edge.
- RUN: clock toggles indefinitely; rst=~ACTIVE; busy_o=1.
- stop_i (RESET or RUN):
  - Next cycle: IDLE, clock=latched init level, rst=ACTIVE.
  - stop_i has priority over any toggle in the same cycle.
- run_i while busy: ignored.
- Input config changes while busy: ignored; the latched copy is used.
- run_i and stop_i together in IDLE: run wins. In RESET/RUN: stop wins.
- Counters saturate never: half counter always wraps at half_period-1; the reset-edge counter stops counting on leaving RESET.
- Latency: run_i sampled at edge k -> busy_o=1 and clock=init level at k+1. First toggle at k+1+half_period.

Optional Feature:
- Macro CLOCK_RST_CYCLE_CNT_EN.
- Defined:
  - Adds output cyc_cnt_o [31:0]: count of clock 0->1 transitions since last entry to RUN.
  - Cleared on entering RUN and on rst_n; wraps at 2^32-1 -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package clock_rst_pkg:
  - state enum (IDLE, RESET, RUN).
  - Default CNT_W constant.
  - Config struct typedef (rst_cycles, half_period, init_level).
- One sub-module, clock_rst_div: half-period counter plus toggle flop, with load/enable/init-level inputs and a rise/fall strobe output.

Test Plan:
- rst_n pulse low then high -> clock=0, rst=ACTIVE(0), busy_o=0, state IDLE held with no run.
- run_i with rst_cycles=10, half_period=31, init=0:
  - clock period 62 clk cycles.
  - rst low through 10 rising edges; rises at the 10th falling toggle.
  - busy_o=1 one cycle after run.
- rst_cycles=0, half_period=0 -> RUN immediately, clock toggles every clk cycle, rst=1 one cycle after run.
- ACTIVE=1, init=1, rst_cycles=2, half_period=4 -> clock starts high, rst=1 for 2 rising edges, then 0.
- stop_i during RESET and during RUN -> next cycle IDLE, clock=init, rst=ACTIVE; run_i during RUN and inputs changed mid-run have no effect.
- With CLOCK_RST_CYCLE_CNT_EN: after 100 rising edges in RUN, cyc_cnt_o=100; stop then restart clears it to 0.
